// File: rtl/cpu_pkg.sv
// Shared CPU constants: register-file geometry and writeback data-source encodings.
// The writeback decode and the register file both take their encodings from here.
package cpu_pkg;

   localparam int unsigned XLEN      = 16;
   localparam int unsigned REG_IDX_W = 3;
   localparam int unsigned NUM_REGS  = 1 << REG_IDX_W;

   typedef logic [XLEN-1:0]      word_t;
   typedef logic [REG_IDX_W-1:0] reg_idx_t;
   typedef logic [2:0]           rfw_sel_t;

   localparam rfw_sel_t RFW_RY   = 3'd0;
   localparam rfw_sel_t RFW_MVHI = 3'd1;
   localparam rfw_sel_t RFW_ALU  = 3'd2;
   localparam rfw_sel_t RFW_PC   = 3'd3;
   localparam rfw_sel_t RFW_LD   = 3'd4;
   localparam rfw_sel_t RFW_IMM  = 3'd5;

   localparam reg_idx_t LINK_REG = reg_idx_t'(NUM_REGS - 1);

   typedef struct packed {
      logic     valid;
      reg_idx_t idx;
      word_t    data;
   } fwd_t;

   // Encodings above RFW_IMM are reserved and must never write the register file.
   function automatic logic rfw_sel_legal(input rfw_sel_t sel);
      return sel <= RFW_IMM;
   endfunction

endpackage

// File: rtl/cpu_wb_mux.sv
// Writeback data-source mux. Purely combinational; sel_ok flags a non-reserved encoding.
module cpu_wb_mux
   import cpu_pkg::*;
(
   input  rfw_sel_t   sel,
   input  word_t      ry_data,
   input  logic [7:0] rx_low,
   input  logic [7:0] imm8,
   input  word_t      alu,
   input  word_t      pc,
   input  word_t      ldata,
   input  word_t      imm,
   output word_t      data,
   output logic       sel_ok
);

   always_comb begin
      data = '0;
      case (sel)
         RFW_RY:   data = ry_data;
         RFW_MVHI: data = {imm8, rx_low};
         RFW_ALU:  data = alu;
         RFW_PC:   data = pc;
         RFW_LD:   data = ldata;
         RFW_IMM:  data = imm;
         default:  data = '0;
      endcase
   end

   assign sel_ok = rfw_sel_legal(sel);

endmodule

// File: rtl/cpu_wb_regfile.sv
// 8 x 16-bit writeback register file: one general write, one link (R7) write, two bypassed
// combinational read ports, and a registered record of the last commit for forwarding.
module cpu_wb_regfile
   import cpu_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       wb_valid,
   input  logic       rf_wr,
   input  logic       ld_r7,
   input  rfw_sel_t   rfw_sel,
   input  reg_idx_t   wb_rx,
   input  word_t      wb_ry_data,
   input  word_t      wb_alu,
   input  word_t      wb_pc,
   input  word_t      wb_ldata,
   input  word_t      wb_imm,
   input  logic [7:0] wb_imm8,
   input  reg_idx_t   rd_addr0,
   input  reg_idx_t   rd_addr1,
   output word_t      rd_data0,
   output word_t      rd_data1,
   output logic       fwd_valid,
   output reg_idx_t   fwd_reg,
   output word_t      fwd_data
);

   word_t regs_q [NUM_REGS];
   fwd_t  fwd_q;

   word_t wr_data;
   logic  sel_ok;
   logic  gen_we;
   logic  link_we;
   logic  link_over_gen;

   // mvhi merges with the stored low byte, never with a value bypassed from this cycle.
   cpu_wb_mux u_mux (
      .sel     (rfw_sel),
      .ry_data (wb_ry_data),
      .rx_low  (regs_q[wb_rx][7:0]),
      .imm8    (wb_imm8),
      .alu     (wb_alu),
      .pc      (wb_pc),
      .ldata   (wb_ldata),
      .imm     (wb_imm),
      .data    (wr_data),
      .sel_ok  (sel_ok)
   );

   assign gen_we        = wb_valid & rf_wr & sel_ok;
   assign link_we       = wb_valid & ld_r7;
   assign link_over_gen = link_we & (wb_rx == LINK_REG);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < int'(NUM_REGS); i++) begin
            regs_q[i] <= '0;
         end
         fwd_q <= '0;
      end else begin
         if (gen_we) begin
            regs_q[wb_rx] <= wr_data;
         end
         // Issued after the general write so the link value wins a collision on R7.
         if (link_we) begin
            regs_q[LINK_REG] <= wb_pc;
         end
         if (gen_we) begin
            fwd_q <= '{valid: 1'b1, idx: wb_rx, data: link_over_gen ? wb_pc : wr_data};
         end else if (link_we) begin
            fwd_q <= '{valid: 1'b1, idx: LINK_REG, data: wb_pc};
         end else begin
            fwd_q.valid <= 1'b0;
         end
      end
   end

   always_comb begin
      rd_data0 = regs_q[rd_addr0];
      rd_data1 = regs_q[rd_addr1];
      if (gen_we && rd_addr0 == wb_rx) rd_data0 = wr_data;
      if (gen_we && rd_addr1 == wb_rx) rd_data1 = wr_data;
      if (link_we && rd_addr0 == LINK_REG) rd_data0 = wb_pc;
      if (link_we && rd_addr1 == LINK_REG) rd_data1 = wb_pc;
      if (reset) begin
         rd_data0 = '0;
         rd_data1 = '0;
      end
   end

   assign fwd_valid = fwd_q.valid;
   assign fwd_reg   = fwd_q.idx;
   assign fwd_data  = fwd_q.data;

endmodule

// File: doc/cpu_wb_regfile.md
CPU_WB_REGFILE -- requirements
Module: cpu_wb_regfile

Interface
REQ-001 SHALL expose clk  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL expose reset  input  1  reset, asynchronous and active-high.
REQ-003 SHALL expose wb_valid  input  1  writeback-stage instruction valid; no write when 0.
REQ-004 SHALL expose rf_wr  input  1  general register write enable from writeback decode.
REQ-005 SHALL expose ld_r7  input  1  link write enable: load R7 with wb_pc.
REQ-006 SHALL expose rfw_sel  input  3  write-data source select.
REQ-007 SHALL expose wb_rx  input  3  destination register index.
REQ-008 SHALL expose wb_ry_data, wb_alu, wb_pc, wb_ldata, wb_imm  input  16 each  candidate write data: Ry value, ALU result, link PC, load data, sign-extended immediate.
REQ-009 SHALL expose wb_imm8  input  8  mvhi immediate byte.
REQ-010 SHALL expose rd_addr0, rd_addr1  input  3 each  read port indices.
REQ-011 SHALL expose rd_data0, rd_data1  output  16 each  read port data.
REQ-012 SHALL expose fwd_valid  output  1, fwd_reg  output  3, fwd_data  output  16  registered record of last committed general write, for upstream forwarding.

Function
REQ-013 SHALL hold 8 x 16-bit registers R0..R7; R0 is an ordinary writable register.
REQ-014 SHALL select write data: sel 0 wb_ry_data; 1 {wb_imm8, R[wb_rx][7:0]}; 2 wb_alu; 3 wb_pc; 4 wb_ldata; 5 wb_imm.
REQ-015 SHALL treat rfw_sel 6 or 7 as reserved: no general write that cycle, regardless of rf_wr.
REQ-016 SHALL commit general write R[wb_rx] <= selected data at the clock edge iff wb_valid & rf_wr & rfw_sel <= 5.
REQ-017 SHALL commit R7 <= wb_pc at the clock edge iff wb_valid & ld_r7.
REQ-018 SHALL, when both writes are enabled and wb_rx = 7, write wb_pc to R7 (ld_r7 wins); when wb_rx != 7, perform both writes in the same cycle.
REQ-019 SHALL read combinationally: rd_dataN = R[rd_addrN], zero-cycle latency.
REQ-020 SHALL bypass: when a write to the read index commits at the next edge, rd_dataN returns the data being written in the current cycle, with ld_r7 priority per REQ-018.
REQ-021 SHALL, for mvhi (sel 1), use the pre-write low byte of R[wb_rx], never a bypassed value.
REQ-022 SHALL register fwd_valid/fwd_reg/fwd_data one cycle after each committed general write; if only ld_r7 commits, they report reg 7 with wb_pc; with no commit, fwd_valid = 0 and fwd_reg/fwd_data hold their values.
REQ-023 SHALL ignore all write controls while wb_valid = 0, with no side effects.

Reset
REQ-024 SHALL clear R0..R7 to 16'h0000 on reset assertion, immediately, without waiting for clk.
REQ-025 SHALL drive fwd_valid = 0, fwd_reg = 0, fwd_data = 0 during and after reset until the first commit.
REQ-026 SHALL, when reset asserts on the same cycle as a write, drop the write; the register stays 0.
REQ-027 SHALL keep rd_dataN = 0 during reset, bypass included.

Structure
REQ-028 SHALL take rfw_sel encodings (RFW_RY..RFW_IMM) and the register index width from a shared cpu_pkg, the same constants the writeback decode uses.
REQ-029 SHALL implement the data-select mux as sub-module cpu_wb_mux (combinational) and keep all state in cpu_wb_regfile.

Verification
REQ-030 SHALL verify reset: write R3 = 16'h1234, assert reset mid-cycle -> R3 reads 16'h0000 before the next edge; fwd_valid = 0.
REQ-031 SHALL verify mvhi: R2 = 16'h00AB, sel 1, imm8 = 8'h5C, rx = 2 -> R2 = 16'h5CAB next cycle; fwd = {1, 2, 16'h5CAB}.
REQ-032 SHALL verify bypass: rf_wr sel 2, wb_alu = 16'hBEEF, rx = 4, rd_addr0 = 4 in the same cycle -> rd_data0 = 16'hBEEF before the edge.
REQ-033 SHALL verify the R7 collision: rf_wr sel 4 rx = 7 with wb_ldata = 16'h1111, plus ld_r7 with wb_pc = 16'h0040 -> R7 = 16'h0040.
REQ-034 SHALL verify dual write: call with ld_r7, wb_pc = 16'h0022, plus rf_wr rx = 1 sel 5 wb_imm = 16'hFFF0 -> R7 = 16'h0022 and R1 = 16'hFFF0.
REQ-035 SHALL verify gating: wb_valid = 0 with rf_wr, or rfw_sel = 6 with wb_valid = 1 -> no register changes and fwd_valid = 0.
